alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 93 +++++++++
 tb/tb_alu_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two valid/ready requesters
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       reqValid,
  output logic [1:0]       reqReady,
  input  logic [WIDTH-1:0] reqA0,
  input  logic [WIDTH-1:0] reqB0,
  input  logic [WIDTH-1:0] reqA1,
  input  logic [WIDTH-1:0] reqB1,
  input  logic [3:0]       reqOp0,
  input  logic [3:0]       reqOp1,
  output logic [1:0]       rspValid,
  input  logic [1:0]       rspReady,
  output logic [WIDTH-1:0] rspData0,
  output logic [WIDTH-1:0] rspData1,
  output logic             rspZero0,
  output logic             rspZero1,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic [3:0]       aluOpCode,
  input  logic [WIDTH-1:0] aluOut,
  input  logic             aluZero
);

  logic [1:0] eligible;
  logic [1:0] grant;
  logic       lastGrant;

  // A requester may issue when its response slot is empty or being drained this cycle;
  // ties go to the requester that was not granted most recently. No grant while in reset.
  always_comb begin
    eligible = reqValid & (~rspValid | rspReady);
    grant    = 2'b00;
    if (reset_n) begin
      if (eligible == 2'b11) begin
        grant = lastGrant ? 2'b01 : 2'b10;
      end else begin
        grant = eligible;
      end
    end
  end

  assign reqReady = grant;

  // Steer the granted requester onto the shared ALU; idle the ALU inputs otherwise.
  always_comb begin
    aluA      = '0;
    aluB      = '0;
    aluOpCode = 4'b0000;
    if (grant[0]) begin
      aluA      = reqA0;
      aluB      = reqB0;
      aluOpCode = reqOp0;
    end else if (grant[1]) begin
      aluA      = reqA1;
      aluB      = reqB1;
      aluOpCode = reqOp1;
    end
  end

  // Capture the ALU result into the granted slot; a new grant takes priority over a drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rspValid  <= 2'b00;
      rspData0  <= '0;
      rspData1  <= '0;
      rspZero0  <= 1'b0;
      rspZero1  <= 1'b0;
      lastGrant <= 1'b1;
    end else begin
      if (grant[0]) begin
        rspData0    <= aluOut;
        rspZero0    <= aluZero;
        rspValid[0] <= 1'b1;
        lastGrant   <= 1'b0;
      end else if (rspValid[0] && rspReady[0]) begin
        rspValid[0] <= 1'b0;
      end
      if (grant[1]) begin
        rspData1    <= aluOut;
        rspZero1    <= aluZero;
        rspValid[1] <= 1'b1;
        lastGrant   <= 1'b1;
      end else if (rspValid[1] && rspReady[1]) begin
        rspValid[1] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset_n;
  logic [1:0]       reqValid;
  logic [1:0]       reqReady;
  logic [WIDTH-1:0] reqA0, reqB0, reqA1, reqB1;
  logic [3:0]       reqOp0, reqOp1;
  logic [1:0]       rspValid;
  logic [1:0]       rspReady;
  logic [WIDTH-1:0] rspData0, rspData1;
  logic             rspZero0, rspZero1;
  logic [WIDTH-1:0] aluA, aluB;
  logic [3:0]       aluOpCode;
  logic [WIDTH-1:0] aluOut;
  logic             aluZero;

  int errors = 0;
  int checks = 0;
  int cnt0   = 0;
  int cnt1   = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqA0(reqA0), .reqB0(reqB0), .reqA1(reqA1), .reqB1(reqB1),
    .reqOp0(reqOp0), .reqOp1(reqOp1),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspData0(rspData0), .rspData1(rspData1),
    .rspZero0(rspZero0), .rspZero1(rspZero1),
    .aluA(aluA), .aluB(aluB), .aluOpCode(aluOpCode),
    .aluOut(aluOut), .aluZero(aluZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: the six defined ops, zero for anything else.
  always_comb begin
    case (aluOpCode)
      4'b0000: aluOut = aluA & aluB;
      4'b0001: aluOut = aluA | aluB;
      4'b0010: aluOut = aluA + aluB;
      4'b0110: aluOut = aluA - aluB;
      4'b0111: aluOut = ($signed(aluA) < $signed(aluB)) ? 32'd1 : 32'd0;
      4'b1100: aluOut = ~(aluA | aluB);
      default: aluOut = 32'd0;
    endcase
    aluZero = (aluOut == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    reqValid = 2'b11;
    rspReady = 2'b00;
    reqA0 = 32'd1; reqB0 = 32'd2; reqOp0 = 4'b0010;
    reqA1 = 32'd3; reqB1 = 32'd4; reqOp1 = 4'b0001;
    tick();
    tick();
    #2;
    // Reset state, with requests pending to confirm grant is held off
    check("rst_rspValid", {30'd0, rspValid}, 32'd0);
    check("rst_rspData0", rspData0, 32'd0);
    check("rst_rspData1", rspData1, 32'd0);
    check("rst_rspZero",  {30'd0, rspZero1, rspZero0}, 32'd0);
    check("rst_reqReady", {30'd0, reqReady}, 32'd0);
    check("rst_aluA",     aluA, 32'd0);
    check("rst_aluOp",    {28'd0, aluOpCode}, 32'd0);
    tick();
    reset_n  = 1'b1;
    reqValid = 2'b00;
    tick();

    // Single ADD on requester 0
    reqA0 = 32'd5; reqB0 = 32'd7; reqOp0 = 4'b0010; reqValid = 2'b01;
    #2;
    check("add_reqReady", {30'd0, reqReady}, 32'h1);
    check("add_aluA",     aluA, 32'd5);
    check("add_aluB",     aluB, 32'd7);
    check("add_aluOp",    {28'd0, aluOpCode}, 32'h2);
    tick();
    reqValid = 2'b00;
    check("add_rspValid", {30'd0, rspValid}, 32'h1);
    check("add_rspData0", rspData0, 32'd12);
    check("add_rspZero0", {31'd0, rspZero0}, 32'd0);
    rspReady = 2'b01;
    tick();
    check("add_drain", {30'd0, rspValid}, 32'h0);
    rspReady = 2'b00;

    // Simultaneous requests immediately after reset
    do_reset();
    reqA0 = 32'd9; reqB0 = 32'd9; reqOp0 = 4'b0110;
    reqA1 = 32'd3; reqB1 = 32'd4; reqOp1 = 4'b0001;
    reqValid = 2'b11;
    #2;
    check("sim_grant0", {30'd0, reqReady}, 32'h1);
    tick();
    reqValid = 2'b10;
    check("sim_rspValid0", {30'd0, rspValid}, 32'h1);
    check("sim_rspData0",  rspData0, 32'd0);
    check("sim_rspZero0",  {31'd0, rspZero0}, 32'd1);
    #2;
    check("sim_grant1", {30'd0, reqReady}, 32'h2);
    tick();
    reqValid = 2'b00;
    check("sim_rspValid1", {30'd0, rspValid}, 32'h3);
    check("sim_rspData1",  rspData1, 32'd7);
    check("sim_rspZero1",  {31'd0, rspZero1}, 32'd0);
    rspReady = 2'b11;
    tick();
    check("sim_drain", {30'd0, rspValid}, 32'h0);

    // Round-robin with both requesters continuously eligible
    reqA0 = 32'd1; reqB0 = 32'd2; reqOp0 = 4'b0010;
    reqA1 = 32'd6; reqB1 = 32'd3; reqOp1 = 4'b0000;
    reqValid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #2;
      check($sformatf("rr_grant_%0d", i), {30'd0, reqReady}, (i % 2 == 0) ? 32'h1 : 32'h2);
      if (reqReady == 2'b01) cnt0++;
      if (reqReady == 2'b10) cnt1++;
      tick();
    end
    check("rr_count0", cnt0, 32'd5);
    check("rr_count1", cnt1, 32'd5);
    check("rr_data0",  rspData0, 32'd3);
    check("rr_data1",  rspData1, 32'd2);
    reqValid = 2'b00;
    tick();
    check("rr_drain", {30'd0, rspValid}, 32'h0);

    // Backpressure on slot 0, requester 1 keeps going, then same-cycle refill
    rspReady = 2'b00;
    reqA0 = 32'd10; reqB0 = 32'd20; reqOp0 = 4'b0010; reqValid = 2'b01;
    tick();
    check("bp_first", rspData0, 32'd30);
    reqA0 = 32'd100; reqB0 = 32'd1;
    reqA1 = 32'd12;  reqB1 = 32'd10; reqOp1 = 4'b0000;
    reqValid = 2'b11;
    #2;
    check("bp_reqReady", {30'd0, reqReady}, 32'h2);
    tick();
    check("bp_hold0",    rspData0, 32'd30);
    check("bp_data1",    rspData1, 32'd8);
    check("bp_rspValid", {30'd0, rspValid}, 32'h3);
    reqValid = 2'b01;
    #2;
    check("bp_stall", {30'd0, reqReady}, 32'h0);
    tick();
    check("bp_hold0b", rspData0, 32'd30);
    rspReady = 2'b01;
    #2;
    check("bp_refill_grant", {30'd0, reqReady}, 32'h1);
    tick();
    check("bp_refill_valid", {30'd0, rspValid}, 32'h3);
    check("bp_refill_data",  rspData0, 32'd101);
    reqValid = 2'b00;
    rspReady = 2'b11;
    tick();
    check("bp_drain", {30'd0, rspValid}, 32'h0);

    // SLT / NOR / undefined op, back-to-back on requester 0
    rspReady = 2'b01;
    reqValid = 2'b01;
    reqA0 = 32'd2; reqB0 = 32'd3; reqOp0 = 4'b0111;
    tick();
    check("slt_data", rspData0, 32'd1);
    check("slt_zero", {31'd0, rspZero0}, 32'd0);
    reqA0 = 32'hFFFF_FFFF; reqB0 = 32'd1; reqOp0 = 4'b0111;
    tick();
    check("slt_neg_data", rspData0, 32'd1);
    reqA0 = 32'd0; reqB0 = 32'd0; reqOp0 = 4'b1100;
    tick();
    check("nor_data", rspData0, 32'hFFFF_FFFF);
    check("nor_zero", {31'd0, rspZero0}, 32'd0);
    reqA0 = 32'd5; reqB0 = 32'd6; reqOp0 = 4'b1111;
    #2;
    check("undef_aluOp", {28'd0, aluOpCode}, 32'hF);
    tick();
    check("undef_data",  rspData0, 32'd0);
    check("undef_zero",  {31'd0, rspZero0}, 32'd1);
    check("undef_valid", {30'd0, rspValid}, 32'h1);
    reqValid = 2'b00;
    tick();

    // Reset in the middle of pending responses
    rspReady = 2'b00;
    reqOp0 = 4'b0010; reqOp1 = 4'b0010;
    reqValid = 2'b11;
    tick();
    tick();
    check("mid_full", {30'd0, rspValid}, 32'h3);
    reqValid = 2'b00;
    reset_n  = 1'b0;
    #1;
    check("mid_async_clear", {30'd0, rspValid}, 32'h0);
    check("mid_data_clear",  rspData0, 32'd0);
    tick();
    reset_n  = 1'b1;
    reqValid = 2'b11;
    #2;
    check("mid_tie_grant0", {30'd0, reqReady}, 32'h1);
    tick();
    check("mid_after", {30'd0, rspValid}, 32'h1);
    reqValid = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
